// File: rtl/btn_step_ctrl_pkg.sv
// Shared constants and types for the button/step front-end.
// Defaults target a 50 MHz board clock with a 1 ms debounce tick.
package btn_step_ctrl_pkg;

    localparam int TICK_DIV_DEFAULT  = 50000;
    localparam int DEB_TICKS_DEFAULT = 20;
    localparam int RUN_TICKS_DEFAULT = 250;

    localparam int BTN_STEP = 0;
    localparam int BTN_RST  = 1;

    typedef enum logic {
        STEP_MANUAL = 1'b0,
        STEP_AUTO   = 1'b1
    } step_mode_e;

    // Bits needed to hold 0..max_val-1, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val);
    endfunction

endpackage

// File: rtl/btn_step_ctrl_debounce_ch.sv
// One button channel: two-flop synchroniser, tick-based debounce counter,
// accepted level register and a one-cycle press pulse on rising levels.
module btn_debounce_ch
    import btn_step_ctrl_pkg::*;
#(
    parameter int DEB_TICKS = DEB_TICKS_DEFAULT
)(
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic tick,
    output logic level,
    output logic press
);

    localparam int DEB_W = cnt_width(DEB_TICKS + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_TICKS - 1);

    logic [1:0]       sync_q;
    logic [DEB_W-1:0] deb_cnt;
    logic             level_d;

    // A new level is accepted only after DEB_TICKS consecutive ticks of
    // disagreement; any agreement in between restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            deb_cnt <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
            press   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw};
            level_d <= level;
            press   <= level & ~level_d;
            if (sync_q[1] == level) begin
                deb_cnt <= '0;
            end else if (tick) begin
                if (deb_cnt == DEB_LAST) begin
                    level   <= ~level;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/btn_step_ctrl.sv
// Button front-end for the single-cycle CPU: debounced levels, press pulses,
// and a step clock-enable that is either manual or auto-repeating.
module btn_step_ctrl
    import btn_step_ctrl_pkg::*;
#(
    parameter int N_BTN     = 4,
    parameter int TICK_DIV  = TICK_DIV_DEFAULT,
    parameter int DEB_TICKS = DEB_TICKS_DEFAULT,
    parameter int RUN_TICKS = RUN_TICKS_DEFAULT,
    parameter int CNT_W     = 16
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic             run_mode,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic             tick,
    output logic             step_pulse,
    output logic             cpu_rst,
    output logic [CNT_W-1:0] step_cnt
);

    localparam int DIV_W = cnt_width(TICK_DIV);
    localparam int RUN_W = cnt_width(RUN_TICKS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_TICKS - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [RUN_W-1:0] run_cnt;
    logic [1:0]       run_sync_q;
    step_mode_e       mode;

    assign mode    = step_mode_e'(run_sync_q[1]);
    assign tick    = (div_cnt == DIV_LAST);
    assign cpu_rst = btn_level[BTN_RST];

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEB_TICKS(DEB_TICKS)
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .raw  (btn_raw[i]),
            .tick (tick),
            .level(btn_level[i]),
            .press(btn_press[i])
        );
    end

    // Free-running divider that paces both debounce and auto-run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt    <= '0;
            run_sync_q <= '0;
        end else begin
            div_cnt    <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            run_sync_q <= {run_sync_q[0], run_mode};
        end
    end

    // Held at zero in manual mode so each entry into auto mode waits a full period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cnt <= '0;
        end else if (mode == STEP_MANUAL) begin
            run_cnt <= '0;
        end else if (tick) begin
            run_cnt <= (run_cnt == RUN_LAST) ? '0 : run_cnt + 1'b1;
        end
    end

    always_comb begin
        step_pulse = 1'b0;
        if (!cpu_rst) begin
            case (mode)
                STEP_MANUAL: step_pulse = btn_press[BTN_STEP];
                STEP_AUTO:   step_pulse = tick && (run_cnt == RUN_LAST);
                default:     step_pulse = 1'b0;
            endcase
        end
    end

    // The reset button's press wins over any step in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_cnt <= '0;
        end else if (btn_press[BTN_RST]) begin
            step_cnt <= '0;
        end else if (step_pulse) begin
            step_cnt <= step_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_btn_step_ctrl.sv
// Scoreboard bench for btn_step_ctrl with small tick/debounce/run constants.
module tb_btn_step_ctrl;

    localparam int N_BTN = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N_BTN-1:0] btn_raw;
    logic             run_mode;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic             tick;
    logic             step_pulse;
    logic             cpu_rst;
    logic [CNT_W-1:0] step_cnt;

    typedef struct {
        logic [CNT_W-1:0] cnt;
        bit               chk_press;
        logic             press0;
    } step_exp_t;

    step_exp_t exp_q[$];
    step_exp_t exp_e;
    int        step_cyc[$];
    int        tests_run      = 0;
    int        tests_failed   = 0;
    int        press0_seen    = 0;
    int        steps_in_reset = 0;
    int        cyc_now        = 0;

    btn_step_ctrl #(
        .N_BTN    (N_BTN),
        .TICK_DIV (4),
        .DEB_TICKS(3),
        .RUN_TICKS(5),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .run_mode  (run_mode),
        .btn_level (btn_level),
        .btn_press (btn_press),
        .tick      (tick),
        .step_pulse(step_pulse),
        .cpu_rst   (cpu_rst),
        .step_cnt  (step_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_now++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkRange(input string name, input int actual, input int lo, input int hi);
        tests_run++;
        if (actual < lo || actual > hi) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    // Monitor: every step strobe pops one expected entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (btn_press[0]) press0_seen++;
            if (step_pulse && btn_level[1]) steps_in_reset++;
            if (step_pulse) begin
                step_cyc.push_back(cyc_now);
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL unexpected_step: got step with step_cnt=%0d, expected none", step_cnt);
                end else begin
                    exp_e = exp_q.pop_front();
                    checkOutput("step_cnt_at_step", 32'(step_cnt), 32'(exp_e.cnt));
                    if (exp_e.chk_press) checkOutput("press0_at_step", 32'(btn_press[0]), 32'(exp_e.press0));
                end
            end
        end
    end

    task automatic tickCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input int ch, input logic val);
        btn_raw[ch] = val;
    endtask

    task automatic waitLevel(input int ch, input logic val, input int max_cyc, output int cyc);
        cyc = 0;
        while (btn_level[ch] !== val && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic pressRelease(input int ch);
        int cyc;
        applyStimulus(ch, 1'b1);
        waitLevel(ch, 1'b1, 40, cyc);
        checkOutput($sformatf("level%0d_rise", ch), 32'(btn_level[ch]), 32'd1);
        tickCycles(3);
        applyStimulus(ch, 1'b0);
        waitLevel(ch, 1'b0, 40, cyc);
        checkOutput($sformatf("level%0d_fall", ch), 32'(btn_level[ch]), 32'd0);
        tickCycles(3);
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rst = 1'b1;
        tickCycles(2);
        rst = 1'b0;
        tickCycles(2);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cyc;
        int start;
        int base;
        int n;
        int ticks_seen;
        bit bounce_moved;

        rst      = 1'b1;
        btn_raw  = '0;
        run_mode = 1'b0;
        tickCycles(3);
        checkOutput("reset_outputs", 32'({btn_level, btn_press, tick, step_pulse, cpu_rst, step_cnt}), 32'd0);
        rst = 1'b0;
        tickCycles(2);

        // 1: clean manual press
        exp_q.push_back('{cnt: 4'd0, chk_press: 1'b1, press0: 1'b1});
        applyStimulus(0, 1'b1);
        waitLevel(0, 1'b1, 40, cyc);
        checkRange("clean_latency", cyc, 9, 15);
        tickCycles(3);
        checkOutput("t1_press_count", 32'(press0_seen), 32'd1);
        checkOutput("t1_step_cnt", 32'(step_cnt), 32'd1);
        applyStimulus(0, 1'b0);
        waitLevel(0, 1'b0, 40, cyc);
        checkOutput("t1_release_level", 32'(btn_level[0]), 32'd0);
        tickCycles(3);
        checkOutput("t1_release_no_press", 32'(press0_seen), 32'd1);

        // 2: bounce then hold
        bounce_moved = 1'b0;
        for (int i = 0; i < 14; i++) begin
            applyStimulus(0, ~btn_raw[0]);
            repeat (3) begin
                @(negedge clk);
                if (btn_level[0] !== 1'b0) bounce_moved = 1'b1;
            end
        end
        checkOutput("t2_bounce_level_moved", 32'(bounce_moved), 32'd0);
        exp_q.push_back('{cnt: 4'd1, chk_press: 1'b1, press0: 1'b1});
        applyStimulus(0, 1'b1);
        waitLevel(0, 1'b1, 40, cyc);
        checkRange("t2_hold_latency", cyc, 9, 15);
        tickCycles(3);
        checkOutput("t2_press_count", 32'(press0_seen), 32'd2);
        checkOutput("t2_step_cnt", 32'(step_cnt), 32'd2);
        applyStimulus(0, 1'b0);
        waitLevel(0, 1'b0, 40, cyc);
        tickCycles(3);

        // 3: auto run with a manual press that must be ignored
        for (int k = 2; k <= 6; k++) exp_q.push_back('{cnt: 4'(k), chk_press: 1'b0, press0: 1'b0});
        base     = step_cyc.size();
        start    = cyc_now;
        run_mode = 1'b1;
        applyStimulus(0, 1'b1);
        tickCycles(25);
        applyStimulus(0, 1'b0);
        n = 25;
        while (step_cyc.size() < base + 5 && n < 150) begin
            @(negedge clk);
            n++;
        end
        run_mode = 1'b0;
        checkOutput("t3_auto_steps", 32'(step_cyc.size() - base), 32'd5);
        if (step_cyc.size() > base) checkRange("t3_first_step_delay", step_cyc[base] - start, 18, 21);
        for (int i = 1; i < 5; i++) begin
            if (base + i < step_cyc.size())
                checkOutput($sformatf("t3_step_spacing%0d", i), 32'(step_cyc[base+i] - step_cyc[base+i-1]), 32'd20);
        end
        tickCycles(5);
        checkOutput("t3_press_count", 32'(press0_seen), 32'd3);
        checkOutput("t3_step_cnt", 32'(step_cnt), 32'd7);

        // 4: cpu reset request during auto run
        exp_q.push_back('{cnt: 4'd7, chk_press: 1'b0, press0: 1'b0});
        run_mode = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t4_first_auto_step", 32'(exp_q.size()), 32'd0);
        applyStimulus(1, 1'b1);
        waitLevel(1, 1'b1, 40, cyc);
        checkOutput("t4_cpu_rst_high", 32'(cpu_rst), 32'd1);
        tickCycles(3);
        checkOutput("t4_step_cnt_cleared", 32'(step_cnt), 32'd0);
        tickCycles(35);
        checkOutput("t4_step_cnt_held", 32'(step_cnt), 32'd0);
        applyStimulus(1, 1'b0);
        waitLevel(1, 1'b0, 40, cyc);
        run_mode = 1'b0;
        checkOutput("t4_cpu_rst_low", 32'(cpu_rst), 32'd0);
        tickCycles(5);
        checkOutput("t4_steps_during_cpu_rst", 32'(steps_in_reset), 32'd0);
        checkOutput("t4_step_cnt_final", 32'(step_cnt), 32'd0);

        // 5: step counter wrap
        pulseReset();
        checkOutput("t5_step_cnt_reset", 32'(step_cnt), 32'd0);
        for (int k = 1; k <= 17; k++) begin
            exp_q.push_back('{cnt: 4'((k - 1) % 16), chk_press: 1'b1, press0: 1'b1});
            pressRelease(0);
            if (k == 15) checkOutput("t5_cnt_after15", 32'(step_cnt), 32'd15);
            if (k == 16) checkOutput("t5_cnt_after16", 32'(step_cnt), 32'd0);
            if (k == 17) checkOutput("t5_cnt_after17", 32'(step_cnt), 32'd1);
        end

        // 6: async reset in the middle of the accept window
        applyStimulus(0, 1'b1);
        tickCycles(2);
        ticks_seen = 0;
        n = 0;
        while (ticks_seen < 2 && n < 20) begin
            @(negedge clk);
            if (tick) ticks_seen++;
            n++;
        end
        @(negedge clk);
        checkOutput("t6_level_before_rst", 32'(btn_level[0]), 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("t6_outputs_in_rst", 32'({btn_level, btn_press, tick, step_pulse, cpu_rst, step_cnt}), 32'd0);
        tickCycles(3);
        exp_q.push_back('{cnt: 4'd0, chk_press: 1'b1, press0: 1'b1});
        rst = 1'b0;
        waitLevel(0, 1'b1, 40, cyc);
        checkRange("t6_relatch_latency", cyc, 9, 15);
        tickCycles(3);
        checkOutput("t6_step_cnt", 32'(step_cnt), 32'd1);
        applyStimulus(0, 1'b0);
        waitLevel(0, 1'b0, 40, cyc);
        tickCycles(3);

        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
